sha256_job_scheduler: RTL and testbench

Dispatches hash jobs to a pool of NUM_CORES simplified SHA-256 cores that share one word-addressed memory map. Jobs (message address, output address, tag) are queued in an internal FIFO, handed to free cores round-robin with a one-cycle start pulse, and reported back on a completion channel with the tag and core index once the core returns to idle. It sits between the top-level job source (nonce sweeper / host) and the core array.

---
 rtl/sha256_job_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_sha256_job_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_job_scheduler.sv
// sha256_job_scheduler: queues hash jobs, dispatches them round-robin to a
// pool of SHA-256 cores and reports each completion with its tag and core id.
module sha256_job_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [15:0]                   job_msg_addr,
    input  logic [15:0]                   job_out_addr,
    input  logic [TAG_W-1:0]              job_tag,
    output logic [NUM_CORES-1:0]          core_start,
    output logic [16*NUM_CORES-1:0]       core_message_addr,
    output logic [16*NUM_CORES-1:0]       core_output_addr,
    input  logic [NUM_CORES-1:0]          core_done,
    output logic                          cmp_valid,
    input  logic                          cmp_ready,
    output logic [TAG_W-1:0]              cmp_tag,
    output logic [2:0]                    cmp_core,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_FREE,
        S_LAUNCH,
        S_RUN,
        S_PEND
    } core_st_e;

    logic [15:0]             r_q_msg [FIFO_DEPTH];
    logic [15:0]             r_q_out [FIFO_DEPTH];
    logic [TAG_W-1:0]        r_q_tag [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic                    r_rst_done;

    core_st_e                r_st [NUM_CORES];
    logic [TAG_W-1:0]        r_core_tag [NUM_CORES];
    logic [NUM_CORES-1:0]    r_rep;
    logic [NUM_CORES-1:0]    r_start;
    logic [16*NUM_CORES-1:0] r_msg;
    logic [16*NUM_CORES-1:0] r_out;
    logic [2:0]              r_disp_ptr;
    logic [2:0]              r_cmp_ptr;
    logic                    r_cmp_valid;
    logic [TAG_W-1:0]        r_cmp_tag;
    logic [2:0]              r_cmp_core;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_hs;
    logic                    w_cmp_load;
    logic                    w_disp_hit;
    logic                    w_cmp_hit;
    logic [2:0]              w_disp_idx;
    logic [2:0]              w_cmp_idx;
    logic [TAG_W-1:0]        w_cmp_tag;
    logic [NUM_CORES-1:0]    w_free;
    logic [NUM_CORES-1:0]    w_pend;
    logic [NUM_CORES-1:0]    w_disp_oh;
    logic [NUM_CORES-1:0]    w_cmp_oh;
    logic [NUM_CORES-1:0]    w_hs_oh;

    function automatic logic [2:0] f_wrap(input logic [2:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CORES) s = s - NUM_CORES;
        return 3'(s);
    endfunction

    // Ready is held low until the first clock after reset release.
    assign job_ready  = r_rst_done && (r_count < CW'(FIFO_DEPTH));
    assign w_push     = job_valid && job_ready;
    assign w_pop      = w_disp_hit && (r_count != '0);
    assign w_hs       = r_cmp_valid && cmp_ready;
    assign w_cmp_load = !r_cmp_valid || cmp_ready;

    always_comb begin
        w_free = '0;
        w_pend = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_free[i] = (r_st[i] == S_FREE);
            w_pend[i] = (r_st[i] == S_PEND) && !r_rep[i];
        end
    end

    // Rotating priority searches, starting after the last winner.
    always_comb begin
        w_disp_hit = 1'b0;
        w_disp_idx = '0;
        w_cmp_hit  = 1'b0;
        w_cmp_idx  = '0;
        for (int j = 0; j < NUM_CORES; j++) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!w_disp_hit && w_free[i] &&
                    3'(i) == f_wrap(r_disp_ptr, j)) begin
                    w_disp_hit = 1'b1;
                    w_disp_idx = 3'(i);
                end
                if (!w_cmp_hit && w_pend[i] &&
                    3'(i) == f_wrap(r_cmp_ptr, j)) begin
                    w_cmp_hit = 1'b1;
                    w_cmp_idx = 3'(i);
                end
            end
        end
    end

    always_comb begin
        w_disp_oh = '0;
        w_cmp_oh  = '0;
        w_hs_oh   = '0;
        w_cmp_tag = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_disp_oh[i] = w_pop && (w_disp_idx == 3'(i));
            w_cmp_oh[i]  = w_cmp_load && w_cmp_hit && (w_cmp_idx == 3'(i));
            w_hs_oh[i]   = w_hs && (r_cmp_core == 3'(i));
            if (w_cmp_idx == 3'(i)) w_cmp_tag = r_core_tag[i];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_msg[r_wr_ptr] <= job_msg_addr;
            r_q_out[r_wr_ptr] <= job_out_addr;
            r_q_tag[r_wr_ptr] <= job_tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop) r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                r_st[i]       <= S_FREE;
                r_core_tag[i] <= '0;
            end
            r_rep      <= '0;
            r_start    <= '0;
            r_msg      <= '0;
            r_out      <= '0;
            r_disp_ptr <= '0;
        end else begin
            r_start <= w_disp_oh;
            if (w_pop) r_disp_ptr <= f_wrap(w_disp_idx, 1);
            for (int i = 0; i < NUM_CORES; i++) begin
                case (r_st[i])
                    S_FREE: begin
                        if (w_disp_oh[i]) begin
                            r_st[i]            <= S_LAUNCH;
                            r_msg[16*i +: 16]  <= r_q_msg[r_rd_ptr];
                            r_out[16*i +: 16]  <= r_q_out[r_rd_ptr];
                            r_core_tag[i]      <= r_q_tag[r_rd_ptr];
                        end
                    end
                    S_LAUNCH: r_st[i] <= S_RUN;
                    S_RUN:    if (core_done[i]) r_st[i] <= S_PEND;
                    S_PEND:   if (w_hs_oh[i]) r_st[i] <= S_FREE;
                endcase
                if (w_cmp_oh[i]) r_rep[i] <= 1'b1;
                else if (w_hs_oh[i]) r_rep[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmp_valid <= 1'b0;
            r_cmp_tag   <= '0;
            r_cmp_core  <= '0;
            r_cmp_ptr   <= '0;
        end else if (w_cmp_load) begin
            r_cmp_valid <= w_cmp_hit;
            if (w_cmp_hit) begin
                r_cmp_tag  <= w_cmp_tag;
                r_cmp_core <= w_cmp_idx;
                r_cmp_ptr  <= f_wrap(w_cmp_idx, 1);
            end
        end
    end

    assign core_start        = r_start;
    assign core_message_addr = r_msg;
    assign core_output_addr  = r_out;
    assign cmp_valid         = r_cmp_valid;
    assign cmp_tag           = r_cmp_tag;
    assign cmp_core          = r_cmp_core;
    assign fifo_count        = r_count;
    assign busy              = (r_count != '0) || !(&w_free) || r_cmp_valid;

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// tb_sha256_job_scheduler: directed and random jobs against a transaction
// model of the queue, round-robin allocation and completion reporting.
module tb_sha256_job_scheduler;
    localparam int NC = 4;
    localparam int TW = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              job_valid = 1'b0;
    logic              job_ready;
    logic [15:0]       job_msg_addr = '0;
    logic [15:0]       job_out_addr = '0;
    logic [TW-1:0]     job_tag = '0;
    logic [NC-1:0]     core_start;
    logic [16*NC-1:0]  core_message_addr;
    logic [16*NC-1:0]  core_output_addr;
    logic [NC-1:0]     core_done = '1;
    logic              cmp_valid;
    logic              cmp_ready = 1'b1;
    logic [TW-1:0]     cmp_tag;
    logic [2:0]        cmp_core;
    logic [3:0]        fifo_count;
    logic              busy;

    sha256_job_scheduler #(.NUM_CORES(NC), .FIFO_DEPTH(8), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_msg_addr(job_msg_addr), .job_out_addr(job_out_addr),
        .job_tag(job_tag), .core_start(core_start),
        .core_message_addr(core_message_addr),
        .core_output_addr(core_output_addr), .core_done(core_done),
        .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
        .cmp_tag(cmp_tag), .cmp_core(cmp_core),
        .fifo_count(fifo_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]   m;
        logic [15:0]   o;
        logic [TW-1:0] t;
    } job_t;

    job_t          mq[$];
    job_t          mjob[NC];
    bit            mbusy[NC];
    bit            mfin[NC];
    int            mptr;
    int            rep_cnt[16];
    int            cnt[NC];
    bit            hold[NC];
    int            lat_fix;
    int            maxcnt;
    int            errors = 0;
    int            checks = 0;
    bit            s_push, s_hs, s_stall;
    job_t          s_job;
    logic [TW-1:0] s_tag;
    logic [2:0]    s_core;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks the outputs produced by the edge just passed.
    task automatic monitor();
        logic [NC-1:0] e;
        int c;
        bit anyb;
        c = -1;
        e = '0;
        if (mq.size() != 0)
            for (int k = 0; k < NC; k++)
                if (c < 0 && !mbusy[(mptr + k) % NC]) c = (mptr + k) % NC;
        if (c >= 0) e[c] = 1'b1;
        check("start", core_start, e);
        if (c >= 0) begin
            job_t j = mq.pop_front();
            check("msg_addr", core_message_addr[16*c +: 16], j.m);
            check("out_addr", core_output_addr[16*c +: 16], j.o);
            mjob[c]  = j;
            mbusy[c] = 1'b1;
            mfin[c]  = 1'b0;
            mptr     = (c + 1) % NC;
        end
        if (s_push) mq.push_back(s_job);
        if (s_hs) begin
            int sc = int'(s_core);
            if (sc >= NC) check("cmp_core_rng", s_core, 0);
            else begin
                check("cmp_fin", {mbusy[sc], mfin[sc]}, 2'b11);
                check("cmp_tag", s_tag, mjob[sc].t);
                rep_cnt[s_tag]++;
                mbusy[sc] = 1'b0;
                mfin[sc]  = 1'b0;
            end
        end
        if (s_stall)
            check("cmp_stable", {cmp_valid, cmp_tag, cmp_core},
                  {1'b1, s_tag, s_core});
        anyb = 1'b0;
        for (int k = 0; k < NC; k++) anyb |= mbusy[k];
        check("count", fifo_count, mq.size());
        check("ready", job_ready, mq.size() < 8);
        check("busy", busy, (mq.size() != 0) || anyb || cmp_valid);
    endtask

    // Core models: done drops on start, rises after a latency unless held.
    task automatic cores();
        for (int i = 0; i < NC; i++) begin
            if (core_start[i]) begin
                core_done[i] = 1'b0;
                cnt[i] = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 30));
            end else if (!core_done[i] && !hold[i]) begin
                if (cnt[i] > 1) cnt[i]--;
                else begin
                    core_done[i] = 1'b1;
                    if (mbusy[i]) mfin[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        s_push  = job_valid && job_ready;
        s_job   = {job_msg_addr, job_out_addr, job_tag};
        s_hs    = cmp_valid && cmp_ready;
        s_stall = cmp_valid && !cmp_ready;
        s_tag   = cmp_tag;
        s_core  = cmp_core;
        @(negedge clk);
        monitor();
        cores();
        if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
    endtask

    task automatic push(input logic [15:0] m, input logic [15:0] o,
                        input logic [TW-1:0] t);
        bit acc;
        int g;
        g = 0;
        job_valid = 1'b1;
        job_msg_addr = m;
        job_out_addr = o;
        job_tag = t;
        do begin
            acc = job_ready;
            tick();
            g++;
        end while (!acc && g < 3000);
        job_valid = 1'b0;
        if (!acc) check("push_timeout", job_ready, 1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || mq.size() != 0) && g < 5000) begin
            tick();
            g++;
        end
        check("idle", busy, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        job_valid = 1'b0;
        #1;
        check("rst_ready", job_ready, 0);
        check("rst_start", core_start, 0);
        check("rst_cmp", cmp_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        mq.delete();
        mptr = 0;
        core_done = '1;
        for (int i = 0; i < NC; i++) begin
            mbusy[i] = 1'b0;
            mfin[i]  = 1'b0;
            cnt[i]   = 0;
            hold[i]  = 1'b0;
        end
    endtask

    task automatic set_hold(input bit v);
        for (int i = 0; i < NC; i++) hold[i] = v;
    endtask

    initial begin
        int g;
        @(negedge clk);
        do_reset();
        tick();

        // single job, long hash
        lat_fix = 150;
        push(16'h0000, 16'h0100, 4'd3);
        tick();
        check("a_start", core_start, 4'b0001);
        check("a_msg", core_message_addr[15:0], 16'h0000);
        check("a_out", core_output_addr[15:0], 16'h0100);
        tick();
        check("a_pulse", core_start, 4'b0000);
        g = 0;
        while (!cmp_valid && g < 400) begin tick(); g++; end
        check("a_cmp", {cmp_valid, cmp_tag, cmp_core}, {1'b1, 4'd3, 3'd0});
        wait_idle();

        // six jobs back to back
        lat_fix = 100;
        maxcnt = 0;
        for (int k = 0; k < 6; k++)
            push(16'(16'h1000 + k), 16'(16'h2000 + k), 4'(k));
        wait_idle();
        check("b_peak", maxcnt <= 5, 1);

        // fill the queue while every core is held
        lat_fix = 3;
        for (int t = 0; t < 16; t++) rep_cnt[t] = 0;
        set_hold(1'b1);
        for (int t = 0; t < 12; t++)
            push(16'(16'h3000 + t), 16'(16'h4000 + t), 4'(t));
        check("c_full_cnt", fifo_count, 8);
        check("c_full_rdy", job_ready, 0);
        job_valid = 1'b1;
        job_tag = 4'd12;
        repeat (10) tick();
        check("c_held", fifo_count, 8);
        hold[2] = 1'b0;
        push(16'h300c, 16'h400c, 4'd12);
        set_hold(1'b0);
        wait_idle();
        for (int t = 0; t < 13; t++) check("c_once", rep_cnt[t], 1);

        // push and pop on the same edge at count 4
        set_hold(1'b1);
        for (int t = 0; t < 8; t++)
            push(16'(16'h5000 + t), 16'(16'h6000 + t), 4'(t));
        repeat (3) tick();
        check("e_cnt4", fifo_count, 4);
        hold[0] = 1'b0;
        g = 0;
        while (mbusy[0] && g < 200) begin tick(); g++; end
        job_valid = 1'b1;
        job_msg_addr = 16'h5008;
        job_out_addr = 16'h6008;
        job_tag = 4'd8;
        tick();
        job_valid = 1'b0;
        check("e_pushpop", fifo_count, 4);
        set_hold(1'b0);
        wait_idle();

        // reset with work in flight
        set_hold(1'b1);
        for (int t = 0; t < 6; t++)
            push(16'(16'h7000 + t), 16'(16'h7100 + t), 4'(t));
        repeat (3) tick();
        do_reset();
        lat_fix = 5;
        push(16'h7777, 16'h7778, 4'd7);
        tick();
        check("f_core0", core_start, 4'b0001);
        wait_idle();

        // cores 1 and 3 finish together with the consumer stalled
        lat_fix = 1;
        set_hold(1'b1);
        for (int t = 8; t < 12; t++)
            push(16'(16'h8000 + t), 16'(16'h9000 + t), 4'(t));
        repeat (3) tick();
        cmp_ready = 1'b0;
        hold[1] = 1'b0;
        hold[3] = 1'b0;
        g = 0;
        while (!cmp_valid && g < 20) begin tick(); g++; end
        check("d_first", {cmp_valid, cmp_core, cmp_tag}, {1'b1, 3'd1, 4'd8});
        repeat (5) tick();
        check("d_still", {cmp_valid, cmp_core}, {1'b1, 3'd1});
        cmp_ready = 1'b1;
        tick();
        check("d_second", {cmp_valid, cmp_core, cmp_tag}, {1'b1, 3'd3, 4'd10});
        set_hold(1'b0);
        wait_idle();

        // random traffic
        lat_fix = 0;
        for (int n = 0; n < 1500; n++) begin
            job_valid = ($urandom_range(0, 2) == 0);
            job_msg_addr = 16'($urandom);
            job_out_addr = 16'($urandom);
            job_tag = 4'($urandom);
            cmp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        job_valid = 1'b0;
        cmp_ready = 1'b1;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
